// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI transfer arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } arb_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_GAP   = 2;

endpackage

// File: rtl/spi_xfer_arbiter_rr.sv
// Round-robin pick: first eligible requester at or after ptr, wrapping.
import spi_arb_pkg::*;

module rr_arbiter #(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         elig,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // scan NREQ positions starting at ptr and keep the first hit
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && elig[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI byte engine between NREQ requesters and runs multi-byte
// bursts with ss held low for the whole burst.
//
//  state | meaning
//  IDLE  | ss high, no grant; pick next eligible requester round-robin
//  SETUP | grant held, ss low, GAP quiet cycles before the first byte
//  LOAD  | hand the requester's TX byte to the engine, pulse start
//  WAIT  | wait for a 0->1 on eng_done, return the RX byte
//  HOLD  | ss high, grant still held for GAP+1 cycles, then release
import spi_arb_pkg::*;

module spi_xfer_arbiter #(
  parameter int NREQ  = DEF_NREQ,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ*8-1:0]     req_tx,
  output logic [NREQ-1:0]       gnt,
  output logic                  tx_rd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  rx_last,
  output logic                  eng_ss,
  output logic                  eng_start,
  output logic [7:0]            eng_data_in,
  input  logic                  eng_done,
  input  logic [7:0]            eng_data_out
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GAP + 1);

  arb_state_t       state;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    rr_ptr;
  logic [LEN_W-1:0] cnt;
  logic [GW-1:0]    gap_cnt;
  logic             done_q;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [LEN_W-1:0] len_sel;
  logic [7:0]       tx_sel;
  logic             done_rise;

  // a requester is eligible only with a non-zero burst length
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
    end
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .elig (elig),
    .ptr  (rr_ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // length of the candidate being picked, TX byte of the granted requester
  always_comb begin
    len_sel = '0;
    tx_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) len_sel = req_len[i*LEN_W +: LEN_W];
      if (gidx == IW'(i))     tx_sel  = req_tx[i*8 +: 8];
    end
  end

  assign done_rise = eng_done && !done_q;

  // burst sequencer with registered engine and client outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      done_q      <= 1'b0;
      eng_ss      <= 1'b1;
      eng_start   <= 1'b0;
      eng_data_in <= '0;
      tx_rd       <= 1'b0;
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      rx_data     <= '0;
    end else begin
      done_q    <= eng_done;
      eng_start <= 1'b0;
      tx_rd     <= 1'b0;
      rx_valid  <= 1'b0;
      rx_last   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt     <= pick_gnt;
            gidx    <= pick_idx;
            cnt     <= len_sel;
            gap_cnt <= GW'(GAP - 1);
            eng_ss  <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (gap_cnt == '0) state <= LOAD;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        LOAD: begin
          eng_data_in <= tx_sel;
          tx_rd       <= 1'b1;
          eng_start   <= 1'b1;
          state       <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            rx_data  <= eng_data_out;
            rx_valid <= 1'b1;
            rx_last  <= (cnt == LEN_W'(1));
            cnt      <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              // HOLD lasts GAP+1 cycles so the grant drops GAP+1 after the last byte
              eng_ss  <= 1'b1;
              gap_cnt <= GW'(GAP);
              state   <= HOLD;
            end else begin
              state <= LOAD;
            end
          end
        end
        HOLD: begin
          if (gap_cnt == '0) begin
            gnt    <= '0;
            rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          eng_ss <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: engine model, burst monitor with RX scoreboard,
// table of grant scenarios and hand-written latency / reset sequences.
module tb_spi_xfer_arbiter;

  localparam int NREQ  = 4;
  localparam int LEN_W = 4;
  localparam int GAP   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_tx;
  logic [3:0]  gnt;
  logic        tx_rd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        eng_ss;
  logic        eng_start;
  logic [7:0]  eng_data_in;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_data_out = 8'h00;

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_len      (req_len),
    .req_tx       (req_tx),
    .gnt          (gnt),
    .tx_rd        (tx_rd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_last      (rx_last),
    .eng_ss       (eng_ss),
    .eng_start    (eng_start),
    .eng_data_in  (eng_data_in),
    .eng_done     (eng_done),
    .eng_data_out (eng_data_out)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // requester TX bytes: base per requester plus bytes already consumed
  logic [7:0] tx_base  [4];
  logic [7:0] byte_idx [4];
  for (genvar g = 0; g < 4; g++) begin : g_tx
    assign req_tx[g*8 +: 8] = tx_base[g] + byte_idx[g];
  end

  // engine model: answers data_in ^ 8'h67 six cycles after start; in level
  // mode done stays high from the previous byte into the next WAIT
  logic       lvl_mode = 1'b0;
  int         eng_cnt  = 0;
  logic [7:0] eng_pend = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      eng_done = 1'b0;
      eng_cnt  = 0;
    end else begin
      if (!lvl_mode) begin
        eng_done     = 1'b0;
        eng_data_out = 8'h5A;
      end
      if (eng_start) begin
        eng_cnt  = 6;
        eng_pend = eng_data_in ^ 8'h67;
      end else if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 4) eng_done = 1'b0;
        if (eng_cnt == 0) begin
          eng_done     = 1'b1;
          eng_data_out = eng_pend;
        end
      end
    end
  end

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // monitor: grant log, burst tracking, latency checks, RX scoreboard
  int          cyc = 0, cur = -1, exp_len = 0, rx_cnt = 0;
  int          t_gnt = 0, t_last_rx = 0, last_burst_rx = 0;
  int          start_total = 0, ss_viol = 0, run_high = 0;
  logic        first_start = 1'b0;
  logic [3:0]  gnt_prev = 4'h0;
  logic [15:0] len_snap = 16'h0;
  logic [7:0]  exp_din;
  logic [8:0]  got;
  logic [8:0]  sb [$];
  int          grant_log [$];

  always @(negedge clk) begin
    if (rst) begin
      cur = -1; gnt_prev = 4'h0; rx_cnt = 0; exp_len = 0;
      first_start = 1'b0; run_high = 0;
      sb.delete();
      for (int i = 0; i < 4; i++) byte_idx[i] = 8'h00;
    end else begin
      cyc++;
      if (gnt != 4'h0 && gnt_prev == 4'h0) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
        cur = oh_idx(gnt);
        grant_log.push_back(cur);
        exp_len = int'(len_snap[cur*4 +: 4]);
        byte_idx[cur] = 8'h00;
        rx_cnt = 0; first_start = 1'b0; t_gnt = cyc;
      end else if (gnt != 4'h0 && gnt != gnt_prev) begin
        chk("gnt_stable", 32'(gnt), 32'(gnt_prev));
      end
      if (eng_start) begin
        start_total++;
        chk("start_ss_low", 32'(eng_ss), 32'd0);
        chk("start_tx_rd", 32'(tx_rd), 32'd1);
        chk("start_in_burst", 32'(cur >= 0), 32'd1);
        if (cur >= 0) begin
          exp_din = tx_base[cur] + byte_idx[cur];
          chk("eng_data_in", 32'(eng_data_in), 32'(exp_din));
          if (!first_start) chk("lat_gnt_start", 32'(cyc - t_gnt), 32'(GAP + 1));
          first_start = 1'b1;
          sb.push_back({exp_din ^ 8'h67, (int'(byte_idx[cur]) + 1 == exp_len)});
          byte_idx[cur] = byte_idx[cur] + 8'd1;
        end
      end else if (tx_rd) begin
        chk("tx_rd_alone", 32'(tx_rd), 32'd0);
      end
      if (rx_valid) begin
        if (sb.size() == 0) chk("rx_unexpected", 32'(rx_valid), 32'd0);
        else begin
          got = sb.pop_front();
          chk("rx_data", 32'(rx_data), 32'(got[8:1]));
          chk("rx_last", 32'(rx_last), 32'(got[0]));
        end
        rx_cnt++;
        t_last_rx = cyc;
      end
      if (gnt == 4'h0 && gnt_prev != 4'h0) begin
        chk("lat_rx_gnt_fall", 32'(cyc - t_last_rx), 32'(GAP + 1));
        chk("burst_len", 32'(rx_cnt), 32'(exp_len));
        last_burst_rx = rx_cnt;
        cur = -1;
      end
      if (gnt == 4'h0 && !eng_ss) ss_viol++;
      if (gnt != 4'h0 && rx_cnt < exp_len && eng_ss) ss_viol++;
      if (eng_ss) run_high++;
      else begin
        if (run_high > 0 && run_high < GAP) ss_viol++;
        run_high = 0;
      end
      gnt_prev = gnt;
    end
    len_snap = req_len;
  end

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [7:0]  base;
    logic        lvl;
    int          n;
    int          exp [5];
  } vec_t;
  vec_t vecs [$];

  task automatic add_vec(input logic [3:0] r, input logic [15:0] l, input logic [7:0] b,
                         input logic lv, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4);
    vec_t v;
    v.req = r; v.len = l; v.base = b; v.lvl = lv; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    @(posedge clk);
    while (grant_log.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (grant_log.size() < n) chk("timeout_grant", 32'(grant_log.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (gnt != 4'h0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", 32'(gnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   sv;
    int   t;
    rst = 1'b1; req = 4'h0; req_len = 16'h0;
    for (int i = 0; i < 4; i++) tx_base[i] = 8'h00;

    // reset values and quiet idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ss", 32'(eng_ss), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_tx_rd", 32'(tx_rd), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_last", 32'(rx_last), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_data_in", 32'(eng_data_in), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_ss", 32'(eng_ss), 32'd1);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_no_start", 32'(start_total), 32'd0);

    add_vec(4'b0001, 16'h0001, 8'hAD, 1'b0, 1, 0, 0, 0, 0, 0);
    add_vec(4'b0100, 16'h0300, 8'h10, 1'b0, 1, 2, 0, 0, 0, 0);
    add_vec(4'b1111, 16'h1111, 8'h20, 1'b0, 5, 0, 1, 2, 3, 0);
    add_vec(4'b1111, 16'h1312, 8'h80, 1'b1, 5, 0, 1, 2, 3, 0);
    add_vec(4'b0010, 16'h0000, 8'h00, 1'b0, 0, 0, 0, 0, 0, 0);
    add_vec(4'b1010, 16'h2000, 8'hC0, 1'b0, 1, 3, 0, 0, 0, 0);
    add_vec(4'b0010, 16'h00F0, 8'hE0, 1'b1, 1, 1, 0, 0, 0, 0);

    for (int vi = 0; vi < vecs.size(); vi++) begin
      v = vecs[vi];
      do_reset();
      lvl_mode = v.lvl;
      for (int i = 0; i < 4; i++) tx_base[i] = v.base + 8'(i * 16);
      grant_log.delete();
      sv = ss_viol;
      @(posedge clk); #1;
      req = v.req; req_len = v.len;
      if (v.n == 0) repeat (40) @(posedge clk);
      else wait_grants(v.n);
      #1 req = 4'h0;
      wait_idle();
      @(posedge clk); #1;
      chk($sformatf("v%0d_ngrants", vi), 32'(grant_log.size()), 32'(v.n));
      for (int k = 0; k < v.n && k < grant_log.size(); k++)
        chk($sformatf("v%0d_grant%0d", vi, k), 32'(grant_log[k]), 32'(v.exp[k]));
      chk($sformatf("v%0d_sb_empty", vi), 32'(sb.size()), 32'd0);
      chk($sformatf("v%0d_ss", vi), 32'(ss_viol - sv), 32'd0);
    end

    // req to gnt latency, req dropped and len changed after grant
    do_reset();
    lvl_mode = 1'b1;
    tx_base[0] = 8'h30;
    @(posedge clk); #1;
    req = 4'b0001; req_len = 16'h0002;
    @(negedge clk);
    chk("lat_req_gnt_0", 32'(gnt), 32'd0);
    @(negedge clk);
    chk("lat_req_gnt_1", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 4'h0; req_len = 16'h000F;
    wait_idle();
    @(posedge clk); #1;
    chk("drop_burst_len", 32'(last_burst_rx), 32'd2);
    req_len = 16'h0;

    // mid-burst reset: move rr_ptr to 2, then reset in WAIT of byte 2 of 4
    do_reset();
    lvl_mode = 1'b0;
    tx_base[1] = 8'h40; tx_base[2] = 8'h50;
    grant_log.delete();
    @(posedge clk); #1;
    req = 4'b0010; req_len = 16'h0010;
    wait_grants(1);
    #1 req = 4'h0;
    wait_idle();
    @(posedge clk); #1;
    req = 4'b0100; req_len = 16'h0400;
    t = 0;
    @(posedge clk);
    while (byte_idx[2] != 8'd2 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    chk("mid_rst_reached_byte2", 32'(byte_idx[2]), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ss", 32'(eng_ss), 32'd1);
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    req = 4'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    @(posedge clk); #1;
    req = 4'b1111; req_len = 16'h1111;
    wait_grants(1);
    #1 req = 4'h0;
    chk("mid_rst_rr_restart", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
